// File: rtl/ysyx_23060180_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and queues {pc,instr} for decode.
// Optional build macro IFU_MISALIGN_CHECK_EN adds fetch_misalign and parks fetch on misaligned redirects.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | request offered when buffer has room
// WAIT  | one request outstanding, waiting for response
module ysyx_23060180_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic        fetch_misalign,
`endif
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          drop;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   redirect_tgt;
  logic          park;
  logic          accept;
  logic          push;
  logic          pop;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;

  assign redirect_tgt   = redirect_pc;
  assign park           = misalign_q;
  assign fetch_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= |redirect_pc[1:0];
    end
  end
`else
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign park         = 1'b0;
`endif

  assign imem_req_valid = (state == S_REQ) && (count < CW'(FIFO_DEPTH)) &&
                          !redirect_valid && !park;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect_valid;
  assign pop            = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      drop   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // a response arriving with a redirect is itself the stale one, so nothing is left to drop
          if (imem_rsp_valid) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (redirect_valid) begin
        pc <= redirect_tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_ysyx_23060180_ifu.sv
// Bench for ysyx_23060180_ifu: cycle vector table for directed corners, then randomized
// memory/decode traffic checked against a fetch-stream model, then a mid-operation reset.
module tb_ysyx_23060180_ifu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060180_ifu dut (
    .clk           (clk),
    .rstn          (rstn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        rsp;
    logic [31:0] rdata;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs [31];

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rdy,
                              input logic rsp, input logic [31:0] rdata, input logic irdy,
                              input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_instr, input logic [31:0] e_ipc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.rsp = rsp; v.rdata = rdata; v.irdy = irdy;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
  endtask

  logic [31:0] exp_fetch, exp_deliver, pend_addr;
  logic        pending, was_pending, flush_chk;
  int          cd, ndeliv;

  initial begin
    vecs[0]  = mk(0, 0, 1, 1, 32'h0BAD_0BAD, 1, 0, 32'h8000_0000, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 1, 1, 32'h8000_0000, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 32'h0010_0093, 1, 0, 32'h8000_0004, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 0, 0, 1, 32'h8000_0004, 1, 32'h0010_0093, 32'h8000_0000);
    vecs[4]  = mk(0, 0, 1, 1, 32'h0000_0013, 0, 0, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0000);
    vecs[5]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0000);
    vecs[6]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0000);
    vecs[7]  = mk(0, 0, 1, 0, 0, 1, 0, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0000);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 1, 32'h8000_0008, 1, 32'h0000_0013, 32'h8000_0004);
    for (int i = 9; i <= 12; i++)
      vecs[i] = mk(0, 0, 0, 0, 0, 1, 1, 32'h8000_0008, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 0, 0, 1, 1, 32'h8000_0008, 0, 0, 0);
    vecs[14] = mk(1, 32'h8000_0100, 1, 0, 0, 1, 0, 32'h8000_000C, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 0, 0, 1, 0, 32'h8000_0100, 0, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 0, 1, 0, 32'h8000_0100, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 32'h8000_0100, 0, 0, 0);
    vecs[18] = mk(0, 0, 1, 0, 0, 1, 1, 32'h8000_0100, 0, 0, 0);
    vecs[19] = mk(0, 0, 1, 1, 32'h1111_1111, 1, 0, 32'h8000_0104, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 0, 0, 0, 1, 32'h8000_0104, 1, 32'h1111_1111, 32'h8000_0100);
    vecs[21] = mk(0, 0, 1, 1, 32'h2222_2222, 0, 0, 32'h8000_0108, 1, 32'h1111_1111, 32'h8000_0100);
    vecs[22] = mk(1, 32'h8000_0200, 1, 1, 32'h9999_9999, 1, 0, 32'h8000_0108, 1, 32'h1111_1111, 32'h8000_0100);
    vecs[23] = mk(0, 0, 1, 0, 0, 1, 1, 32'h8000_0200, 0, 0, 0);
    vecs[24] = mk(1, 32'hFFFF_FFFC, 1, 1, 32'h3333_3333, 1, 0, 32'h8000_0204, 0, 0, 0);
    vecs[25] = mk(0, 0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    vecs[26] = mk(0, 0, 1, 1, 32'h4444_4444, 1, 0, 32'h0000_0000, 0, 0, 0);
    vecs[27] = mk(0, 0, 1, 0, 0, 1, 1, 32'h0000_0000, 1, 32'h4444_4444, 32'hFFFF_FFFC);
    vecs[28] = mk(1, 32'h8000_0302, 1, 0, 0, 1, 0, 32'h0000_0004, 0, 0, 0);
    vecs[29] = mk(0, 0, 1, 1, 32'h5555_5555, 1, 0, 32'h8000_0300, 0, 0, 0);
    vecs[30] = mk(0, 0, 1, 0, 0, 1, 1, 32'h8000_0300, 0, 0, 0);

    rstn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      rstn           = 1'b1;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rsp;
      imem_rsp_data  = vecs[i].rdata;
      instr_ready    = vecs[i].irdy;
      #1;
      chk($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv || i == 0) begin
        chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
        chk($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].e_ipc);
      end
    end

    // randomized traffic: delivered pcs must follow the fetch stream restarted by each redirect
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    exp_fetch   = 32'h8000_0000;
    exp_deliver = 32'h8000_0000;
    pending     = 1'b0;
    pend_addr   = 32'h0;
    flush_chk   = 1'b0;
    cd          = 0;
    ndeliv      = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rstn           = 1'b1;
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      imem_req_ready = ($urandom_range(0, 2) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      if (pending) begin
        if (cd == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memfn(pend_addr);
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = $urandom;
          cd--;
        end
      end else begin
        imem_rsp_valid = ($urandom_range(0, 7) == 0);
        imem_rsp_data  = $urandom;
      end
      #1;
      if (flush_chk) chk("flush instr_valid", 32'(instr_valid), 32'h0);
      flush_chk   = 1'b0;
      was_pending = pending;
      if (pending && imem_rsp_valid) pending = 1'b0;
      if (redirect_valid) chk("redirect blocks req", 32'(imem_req_valid), 32'h0);
      if (imem_req_valid) begin
        chk("fetch addr", imem_addr, exp_fetch);
        chk("one outstanding", 32'(was_pending), 32'h0);
        if (imem_req_ready) begin
          pending   = 1'b1;
          pend_addr = imem_addr;
          cd        = $urandom_range(0, 3);
          exp_fetch = exp_fetch + 32'd4;
        end
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        chk("deliver pc", instr_pc, exp_deliver);
        chk("deliver instr", instr, memfn(exp_deliver));
        exp_deliver = exp_deliver + 32'd4;
        ndeliv++;
      end
      if (redirect_valid) begin
        exp_fetch   = redirect_pc & 32'hFFFF_FFFC;
        exp_deliver = redirect_pc & 32'hFFFF_FFFC;
        flush_chk   = 1'b1;
      end
    end
    chk("random deliveries >= 100", 32'(ndeliv >= 100), 32'h1);

    // reset in the middle of traffic, then a stale response while idle
    @(negedge clk);
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = $urandom;
    instr_ready    = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset req_valid", 32'(imem_req_valid), 32'h0);
    chk("midreset imem_addr", imem_addr, 32'h8000_0000);
    chk("midreset instr_valid", 32'(instr_valid), 32'h0);
    chk("midreset instr", instr, 32'h0);
    chk("midreset instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post-reset idle req_valid", 32'(imem_req_valid), 32'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("post-reset req_valid", 32'(imem_req_valid), 32'h1);
    chk("post-reset imem_addr", imem_addr, 32'h8000_0000);
    chk("post-reset instr_valid", 32'(instr_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
